serial_deser: RTL and testbench
===============================

# serial_deser

Serial-to-parallel deserializer that sits directly downstream of the team's parallel-to-serial shift register. It collects a framed LSB-first bit stream into DATA_W-bit words and presents each word on a valid/ready output port. The block detects framing errors (restart mid-frame) and overruns (word completed while the previous one is still unaccepted).

## Interface
- DATA_W, default 4: bits per word; legal range 2..16.
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_sval  input  1  serial bit qualifier; i_sdata/i_sof sampled only when high.
- i_sdata  input  1  serial data bit, LSB of word first.
- i_sof  input  1  start of frame; marks bit 0 of a word, meaningful only with i_sval.
- i_ready  input  1  downstream accepts o_data when high with o_valid.
- o_data  output  DATA_W  assembled word, stable while o_valid high.
- o_valid  output  1  word available; held until accepted.
- o_busy  output  1  high while a frame is partially received (state SHIFT).
- o_err  output  1  one-cycle pulse: frame aborted by a new i_sof.
- o_ovf  output  1  one-cycle pulse: completed word dropped due to overrun.

## Operation
- Internal: shift register sh[DATA_W-1:0], bit counter cnt (0..DATA_W-1), state IDLE/SHIFT, output register plus valid flag.
- Reset values: state IDLE, cnt 0, sh 0, o_data 0, o_valid 0, o_busy 0, o_err 0, o_ovf 0.
- IDLE:
  - i_sval & i_sof: sh[0] <= i_sdata, cnt <= 1, go SHIFT.
  - i_sval & !i_sof: bit discarded, no flag, stay IDLE.
  - !i_sval: no change.
- SHIFT:
  - !i_sval: hold (gaps between bits allowed, unlimited length).
  - i_sval & !i_sof, cnt < DATA_W-1: sh[cnt] <= i_sdata, cnt <= cnt+1.
  - i_sval & !i_sof, cnt == DATA_W-1: word = {i_sdata, sh[DATA_W-2:0]} completes; cnt <= 0, go IDLE.
  - i_sval & i_sof: o_err pulses; partial word discarded; sh[0] <= i_sdata, cnt <= 1, stay SHIFT.
- Word completion into output register:
  - If output empty (o_valid 0), or o_valid & i_ready in same cycle: o_data <= word, o_valid <= 1.
  - If o_valid & !i_ready: word dropped, o_ovf pulses, o_data/o_valid unchanged.
- Output handshake: transfer occurs on any edge with o_valid & i_ready; o_valid falls next cycle unless a word completes that same cycle (then o_valid stays 1 with new data).
- o_busy equals (state == SHIFT).
- Unused sh bits not cleared between frames; every bit is overwritten before completion.

## Timing
- Latency: last bit sampled at edge N; o_valid and o_data valid after edge N (visible in cycle N+1).
- Minimum frame length DATA_W i_sval cycles; back-to-back frames allowed with i_sof in the cycle right after the last bit, sustaining one word per DATA_W cycles when i_ready held high.
- o_err and o_ovf asserted for exactly one cycle, registered, after the offending edge.
- o_err and o_ovf never coincide (abort never completes a word).
- Asynchronous reset mid-frame or with o_valid high: all state and outputs return to reset values immediately; partial and pending words lost; first frame after release must start with i_sof.
- i_ready has no effect when o_valid low; i_ready is not required to be stable.

## Test plan
- DATA_W=4, i_ready=1, contiguous i_sval with i_sof on first bit, bits 1,0,1,1 -> o_valid one cycle after 4th bit, o_data=4'hD, o_busy high for 3 cycles then low.
- Same frame with i_sval low for 2 cycles between bits 2 and 3 -> o_data=4'hD, completion delayed by 2 cycles, no flags.
- Bits 1,1 then i_sof with bits 0,0,1,0 -> o_err pulse one cycle after 3rd sampled bit, single word o_data=4'h4.
- i_ready=0, frames 4'h3 then 4'hA -> o_data holds 4'h3, o_ovf pulses once at 2nd completion; raise i_ready -> o_valid drops next cycle.
- Back-to-back frames 4'h1, 4'h2, 4'h3 with i_ready=1 -> three words in order, o_valid pulses every 4 cycles, no flags; i_sval bits without i_sof in IDLE ignored.
- Assert i_rst_n low after 2 bits and with o_valid high -> all outputs 0 immediately; post-reset frame 4'h6 received correctly.

Source files
------------

// File: rtl/serial_deser.sv
// serial_deser: collects a framed LSB-first serial stream into DATA_W-bit
// words and presents them on a valid/ready port. Flags a restart mid-frame
// (o_err) and a completed word lost to an unaccepted output (o_ovf).
module serial_deser #(
   parameter int unsigned DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_sval,
   input  logic              i_sdata,
   input  logic              i_sof,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_err,
   output logic              o_ovf
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] sh;

   logic              word_done;
   logic              abort;
   logic              start;
   logic [DATA_W-1:0] word;

   // Decode this cycle's event: frame start, abort by restart, or word completion.
   always_comb begin
      word_done = 1'b0;
      abort     = 1'b0;
      start     = 1'b0;
      word      = sh;
      word[DATA_W-1] = i_sdata;
      if (i_sval) begin
         if (i_sof) begin
            start = 1'b1;
            abort = (state == ST_SHIFT);
         end else if (state == ST_SHIFT && cnt == CNT_LAST) begin
            word_done = 1'b1;
         end
      end
   end

   // Frame state machine, bit counter and shift register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sh    <= '0;
      end else if (start) begin
         sh[0] <= i_sdata;
         cnt   <= CNT_ONE;
         state <= ST_SHIFT;
      end else if (word_done) begin
         cnt   <= '0;
         state <= ST_IDLE;
      end else if (i_sval && state == ST_SHIFT) begin
         for (int unsigned i = 1; i < DATA_W - 1; i++) begin
            if (cnt == CNT_W'(i)) begin
               sh[i] <= i_sdata;
            end
         end
         cnt <= cnt + CNT_ONE;
      end
   end

   // Output register, valid/ready handshake and one-cycle error/overrun pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         o_ovf   <= 1'b0;
      end else begin
         o_err <= abort;
         o_ovf <= word_done && o_valid && !i_ready;
         if (word_done && (!o_valid || i_ready)) begin
            o_data  <= word;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: directed frames with literal expectations, then
// randomized stimulus compared every cycle against a queue-based model.
module tb_serial_deser;

   localparam int DW = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_sval = 1'b0;
   logic          i_sdata = 1'b0;
   logic          i_sof = 1'b0;
   logic          i_ready = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_busy;
   logic          o_err;
   logic          o_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   serial_deser #(.DATA_W(DW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sval  (i_sval),
      .i_sdata (i_sdata),
      .i_sof   (i_sof),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_err   (o_err),
      .o_ovf   (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: frame collected as a bit queue, word value by arithmetic.
   bit       m_active;
   bit       m_bits[$];
   bit       m_valid;
   int       m_data;
   bit       m_err;
   bit       m_ovf;

   always @(posedge i_clk or negedge i_rst_n) begin
      int  w;
      bit  done;
      bit  accepted;
      if (!i_rst_n) begin
         m_active = 0;
         m_bits.delete();
         m_valid = 0;
         m_data  = 0;
         m_err   = 0;
         m_ovf   = 0;
      end else begin
         m_err = 0;
         m_ovf = 0;
         done  = 0;
         w     = 0;
         accepted = m_valid && i_ready;
         if (i_sval) begin
            if (i_sof) begin
               if (m_active) m_err = 1;
               m_bits.delete();
               m_bits.push_back(i_sdata);
               m_active = 1;
            end else if (m_active) begin
               m_bits.push_back(i_sdata);
               if (m_bits.size() == DW) begin
                  foreach (m_bits[k]) w += int'(m_bits[k]) << k;
                  done = 1;
                  m_active = 0;
                  m_bits.delete();
               end
            end
         end
         if (accepted) m_valid = 0;
         if (done) begin
            if (m_valid) m_ovf = 1;
            else begin
               m_valid = 1;
               m_data  = w;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   bit cmp_en = 0;
   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("cyc_valid", 32'(o_valid), 32'(m_valid));
         check("cyc_data",  32'(o_data),  32'(m_data));
         check("cyc_busy",  32'(o_busy),  32'(m_active));
         check("cyc_err",   32'(o_err),   32'(m_err));
         check("cyc_ovf",   32'(o_ovf),   32'(m_ovf));
      end
   end

   // One serial cycle: drive inputs, let one edge sample them, settle.
   task automatic step(input bit sval, input bit sdata, input bit sof);
      i_sval  = sval;
      i_sdata = sdata;
      i_sof   = sof;
      @(posedge i_clk);
      #2;
   endtask

   task automatic send_frame(input int value);
      for (int b = 0; b < DW; b++) step(1'b1, value[b], b == 0);
      i_sval = 1'b0;
      i_sof  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int rv;
      #3;
      check("rst_valid", 32'(o_valid), 0);
      check("rst_data",  32'(o_data),  0);
      check("rst_busy",  32'(o_busy),  0);
      check("rst_flags", 32'({o_err, o_ovf}), 0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b1;
      cmp_en  = 1;
      i_ready = 1'b1;
      idle(2);

      // Frame 1,0,1,1 -> 4'hD, busy for three cycles
      step(1, 1, 1); check("t1_busy1", 32'(o_busy), 1);
      step(1, 0, 0); check("t1_busy2", 32'(o_busy), 1);
      step(1, 1, 0); check("t1_busy3", 32'(o_busy), 1);
      step(1, 1, 0);
      check("t1_valid", 32'(o_valid), 1);
      check("t1_data",  32'(o_data),  32'hD);
      check("t1_busy4", 32'(o_busy),  0);
      check("t1_model", 32'(m_data),  32'hD);
      idle(2);

      // Same frame with a 2-cycle gap between bits 2 and 3
      step(1, 1, 1); step(1, 0, 0);
      idle(2);
      check("t2_busy_gap", 32'(o_busy), 1);
      step(1, 1, 0);
      check("t2_valid_early", 32'(o_valid), 0);
      step(1, 1, 0);
      check("t2_valid", 32'(o_valid), 1);
      check("t2_data",  32'(o_data),  32'hD);
      idle(2);

      // Abort after two bits, then 0,0,1,0 -> err pulse, word 4'h4
      step(1, 1, 1); step(1, 1, 0);
      step(1, 0, 1);
      check("t3_err",   32'(o_err),  1);
      check("t3_busy",  32'(o_busy), 1);
      step(1, 0, 0);
      check("t3_err_once", 32'(o_err), 0);
      step(1, 1, 0); step(1, 0, 0);
      check("t3_valid", 32'(o_valid), 1);
      check("t3_data",  32'(o_data),  32'h4);
      idle(2);

      // Overrun: ready low, frames 3 then A
      i_ready = 1'b0;
      send_frame(32'h3);
      check("t4_data1", 32'(o_data), 32'h3);
      send_frame(32'hA);
      check("t4_ovf",   32'(o_ovf),   1);
      check("t4_hold",  32'(o_data),  32'h3);
      check("t4_valid", 32'(o_valid), 1);
      idle(1);
      check("t4_ovf_once", 32'(o_ovf), 0);
      i_ready = 1'b1;
      idle(1);
      check("t4_drop", 32'(o_valid), 0);
      idle(1);

      // Stray bits in IDLE are ignored, then back-to-back frames 1,2,3
      step(1, 1, 0); step(1, 0, 0);
      check("t5_idle_busy", 32'(o_busy), 0);
      send_frame(32'h1);
      check("t5_w1", 32'(o_data), 32'h1);
      send_frame(32'h2);
      check("t5_w2", 32'(o_data), 32'h2);
      send_frame(32'h3);
      check("t5_w3", 32'(o_data), 32'h3);
      check("t5_flags", 32'({o_err, o_ovf}), 0);
      idle(2);

      // Async reset mid-frame with a word pending
      i_ready = 1'b0;
      send_frame(32'h9);
      step(1, 1, 1); step(1, 0, 0);
      #1 i_rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(o_valid), 0);
      check("t6_rst_data",  32'(o_data),  0);
      check("t6_rst_busy",  32'(o_busy),  0);
      @(posedge i_clk);
      #2 i_rst_n = 1'b1;
      i_ready = 1'b1;
      step(1, 1, 0);
      check("t6_no_sof", 32'(o_busy), 0);
      send_frame(32'h6);
      check("t6_data", 32'(o_data), 32'h6);
      idle(2);

      // Randomized stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         rv = $urandom;
         i_ready = (rv[3:0] != 0) ? ((n / 64) % 2 == 0 ? 1'b1 : rv[4]) : 1'b0;
         if (n == 1700) begin
            #1 i_rst_n = 1'b0;
            #1 i_rst_n = 1'b1;
         end
         step(rv[6:5] != 0, rv[7], rv[11:8] == 0);
      end
      idle(2);
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
